// File: rtl/axi4_aw_buffer_cfg.sv
// AXI4 write-address channel buffer: circular FIFO between the slave AW port
// and the RAB lookup, with optional empty-bypass, downstream stall, occupancy
// count and almost-full flag.
module axi4_aw_buffer_cfg #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int BUFFER_DEPTH   = 4,
  parameter bit FALL_THROUGH   = 1'b0,
  parameter int AFULL_THRESH   = BUFFER_DEPTH - 1
) (
  input  logic                             axi4_aclk,
  input  logic                             axi4_arstn,
  input  logic [AXI_ID_WIDTH-1:0]          s_axi4_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]        s_axi4_awaddr,
  input  logic [7:0]                       s_axi4_awlen,
  input  logic [2:0]                       s_axi4_awsize,
  input  logic [1:0]                       s_axi4_awburst,
  input  logic                             s_axi4_awlock,
  input  logic [2:0]                       s_axi4_awprot,
  input  logic [3:0]                       s_axi4_awcache,
  input  logic [3:0]                       s_axi4_awregion,
  input  logic [3:0]                       s_axi4_awqos,
  input  logic [AXI_USER_WIDTH-1:0]        s_axi4_awuser,
  input  logic                             s_axi4_awvalid,
  output logic                             s_axi4_awready,
  output logic [AXI_ID_WIDTH-1:0]          m_axi4_awid,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axi4_awaddr,
  output logic [7:0]                       m_axi4_awlen,
  output logic [2:0]                       m_axi4_awsize,
  output logic [1:0]                       m_axi4_awburst,
  output logic                             m_axi4_awlock,
  output logic [2:0]                       m_axi4_awprot,
  output logic [3:0]                       m_axi4_awcache,
  output logic [3:0]                       m_axi4_awregion,
  output logic [3:0]                       m_axi4_awqos,
  output logic [AXI_USER_WIDTH-1:0]        m_axi4_awuser,
  output logic                             m_axi4_awvalid,
  input  logic                             m_axi4_awready,
  input  logic                             stall_i,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] occupancy_o,
  output logic                             almost_full_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int EW = 29 + AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH;
  localparam logic [CW-1:0] FULL_CNT  = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

  logic [EW-1:0] mem [BUFFER_DEPTH];
  logic [EW-1:0] s_entry, out_entry;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, bypass, push, pop, do_wr, do_rd;

  assign s_entry = {s_axi4_awid, s_axi4_awaddr, s_axi4_awlen, s_axi4_awsize,
                    s_axi4_awburst, s_axi4_awlock, s_axi4_awprot, s_axi4_awcache,
                    s_axi4_awregion, s_axi4_awqos, s_axi4_awuser};

  assign empty  = (count == '0);
  // Bypass only exists in fall-through mode and only while nothing is stored,
  // so ordering is preserved: a stored beat always drains before a new one.
  assign bypass = FALL_THROUGH ? empty : 1'b0;

  // Ready depends on registered count only, never on the master side.
  assign s_axi4_awready = (count != FULL_CNT);

  assign out_entry      = bypass ? s_entry : mem[rd_ptr];
  assign m_axi4_awvalid = (bypass ? s_axi4_awvalid : !empty) & !stall_i;

  assign {m_axi4_awid, m_axi4_awaddr, m_axi4_awlen, m_axi4_awsize,
          m_axi4_awburst, m_axi4_awlock, m_axi4_awprot, m_axi4_awcache,
          m_axi4_awregion, m_axi4_awqos, m_axi4_awuser} = out_entry;

  assign push = s_axi4_awvalid & s_axi4_awready;
  assign pop  = m_axi4_awvalid & m_axi4_awready;
  // A bypassed beat that leaves immediately never touches the storage.
  assign do_wr = push & !(bypass & pop);
  assign do_rd = pop & !bypass;

  assign occupancy_o   = count;
  assign almost_full_o = (count >= AFULL_CNT);

  // Pointer and count update; reset discards all stored beats.
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge axi4_aclk) begin
    if (do_wr) mem[wr_ptr] <= s_entry;
  end

endmodule

// File: tb/tb_axi4_aw_buffer_cfg.sv
// Bench for axi4_aw_buffer_cfg: two instances (registered and fall-through,
// 64-bit address, depth 4), a per-instance scoreboard queue, a vector table
// for depth/wrap/full/stall, and hand-written streaming and reset sequences.
module tb_axi4_aw_buffer_cfg;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [2:0]  prot;
    logic [3:0]  cache;
    logic [3:0]  region;
    logic [3:0]  qos;
    logic [3:0]  user;
  } aw_t;

  typedef struct {
    logic        sv;
    logic [63:0] addr;
    logic        mr;
    logic        st;
    logic        e_rdy;
    logic        e_vld;
    int          e_occ;
    logic        e_af;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  aw_t  [1:0] s_aw, m_aw;
  logic [1:0] s_valid, s_ready, m_valid, m_ready, stall, afull;
  logic [1:0][2:0] occ;

  int checks = 0;
  int errors = 0;
  aw_t q0[$];
  aw_t q1[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi4_aw_buffer_cfg #(
      .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .AXI_ADDR_WIDTH(64),
      .BUFFER_DEPTH(4), .FALL_THROUGH(g == 1), .AFULL_THRESH(3)
    ) u_dut (
      .axi4_aclk(clk), .axi4_arstn(rst_n),
      .s_axi4_awid(s_aw[g].id), .s_axi4_awaddr(s_aw[g].addr),
      .s_axi4_awlen(s_aw[g].len), .s_axi4_awsize(s_aw[g].size),
      .s_axi4_awburst(s_aw[g].burst), .s_axi4_awlock(s_aw[g].lock),
      .s_axi4_awprot(s_aw[g].prot), .s_axi4_awcache(s_aw[g].cache),
      .s_axi4_awregion(s_aw[g].region), .s_axi4_awqos(s_aw[g].qos),
      .s_axi4_awuser(s_aw[g].user),
      .s_axi4_awvalid(s_valid[g]), .s_axi4_awready(s_ready[g]),
      .m_axi4_awid(m_aw[g].id), .m_axi4_awaddr(m_aw[g].addr),
      .m_axi4_awlen(m_aw[g].len), .m_axi4_awsize(m_aw[g].size),
      .m_axi4_awburst(m_aw[g].burst), .m_axi4_awlock(m_aw[g].lock),
      .m_axi4_awprot(m_aw[g].prot), .m_axi4_awcache(m_aw[g].cache),
      .m_axi4_awregion(m_aw[g].region), .m_axi4_awqos(m_aw[g].qos),
      .m_axi4_awuser(m_aw[g].user),
      .m_axi4_awvalid(m_valid[g]), .m_axi4_awready(m_ready[g]),
      .stall_i(stall[g]), .occupancy_o(occ[g]), .almost_full_o(afull[g])
    );
  end

  // Deterministic beat with every field derived from id/addr.
  function automatic aw_t mk(input logic [3:0] id, input logic [63:0] addr);
    aw_t b;
    logic [15:0] h;
    h = addr[15:0] ^ {id, id, id, id};
    b.id = id; b.addr = addr; b.len = h[7:0]; b.size = h[10:8];
    b.burst = h[12:11]; b.lock = h[13]; b.prot = h[15:13];
    b.cache = h[3:0] ^ 4'h5; b.region = h[7:4]; b.qos = h[11:8]; b.user = ~id;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on leave (same-cycle order
  // push-then-pop so fall-through bypass is covered).
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (s_valid[0] && s_ready[0]) q0.push_back(s_aw[0]);
      if (s_valid[1] && s_ready[1]) q1.push_back(s_aw[1]);
      if (m_valid[0] && m_ready[0]) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb0_unexpected: got id %0h addr %0h expected none", m_aw[0].id, m_aw[0].addr);
        end else begin
          aw_t e;
          e = q0.pop_front();
          if (m_aw[0] !== e) begin
            errors++;
            $display("FAIL sb0_beat: got %0h expected %0h", m_aw[0], e);
          end
        end
      end
      if (m_valid[1] && m_ready[1]) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected: got id %0h addr %0h expected none", m_aw[1].id, m_aw[1].addr);
        end else begin
          aw_t e;
          e = q1.pop_front();
          if (m_aw[1] !== e) begin
            errors++;
            $display("FAIL sb1_beat: got %0h expected %0h", m_aw[1], e);
          end
        end
      end
    end
  end

  task automatic add(input logic sv, input logic [63:0] a, input logic mr, input logic st,
                     input logic rdy, input logic vld, input int o, input logic af);
    vec_t v;
    v.sv = sv; v.addr = a; v.mr = mr; v.st = st;
    v.e_rdy = rdy; v.e_vld = vld; v.e_occ = o; v.e_af = af;
    vecs.push_back(v);
  endtask

  initial begin
    // Depth, wrap and drain: ready returns the cycle after the first pop.
    add(1, 64'h1000, 0, 0, 1, 0, 0, 0);
    add(1, 64'h2000, 0, 0, 1, 1, 1, 0);
    add(1, 64'h3000, 0, 0, 1, 1, 2, 0);
    add(1, 64'h4000, 0, 0, 1, 1, 3, 1);
    add(0, 64'h0,    0, 0, 0, 1, 4, 1);
    add(0, 64'h0,    1, 0, 0, 1, 4, 1);
    add(0, 64'h0,    1, 0, 1, 1, 3, 1);
    add(0, 64'h0,    1, 0, 1, 1, 2, 0);
    add(0, 64'h0,    1, 0, 1, 1, 1, 0);
    add(0, 64'h0,    1, 0, 1, 0, 0, 0);
    // Full with a simultaneous pop: one pop, no push, push next cycle.
    add(1, 64'h5000, 0, 0, 1, 0, 0, 0);
    add(1, 64'h6000, 0, 0, 1, 1, 1, 0);
    add(1, 64'h7000, 0, 0, 1, 1, 2, 0);
    add(1, 64'h8000, 0, 0, 1, 1, 3, 1);
    add(1, 64'h9000, 1, 0, 0, 1, 4, 1);
    add(1, 64'h9000, 0, 0, 1, 1, 3, 1);
    add(0, 64'h0,    1, 0, 0, 1, 4, 1);
    add(0, 64'h0,    1, 0, 1, 1, 3, 1);
    add(0, 64'h0,    1, 0, 1, 1, 2, 0);
    add(0, 64'h0,    1, 0, 1, 1, 1, 0);
    add(0, 64'h0,    1, 0, 1, 0, 0, 0);
    // Stall: two beats held for five cycles, then consecutive drain.
    add(1, 64'hA000, 0, 0, 1, 0, 0, 0);
    add(1, 64'hB000, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 64'h0, 1, 1, 1, 0, 2, 0);
    add(0, 64'h0,    1, 0, 1, 1, 2, 0);
    add(0, 64'h0,    1, 0, 1, 1, 1, 0);
    add(0, 64'h0,    1, 0, 1, 0, 0, 0);

    rst_n = 1'b0;
    s_valid = '0; m_ready = '0; stall = '0;
    s_aw[0] = mk(4'h0, 64'h0);
    s_aw[1] = mk(4'h0, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_ready%0d", g), 64'(s_ready[g]), 64'd1);
      chk($sformatf("rst_valid%0d", g), 64'(m_valid[g]), 64'd0);
      chk($sformatf("rst_occ%0d", g),   64'(occ[g]),     64'd0);
      chk($sformatf("rst_afull%0d", g), 64'(afull[g]),   64'd0);
    end

    // Table-driven vectors on the registered instance.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      s_valid[0] = vecs[i].sv;
      s_aw[0]    = mk(4'(i), vecs[i].addr);
      m_ready[0] = vecs[i].mr;
      stall[0]   = vecs[i].st;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(s_ready[0]), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 64'(m_valid[0]), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_occ", i),   64'(occ[0]),     64'(vecs[i].e_occ));
      chk($sformatf("v%0d_afull", i), 64'(afull[0]),   64'(vecs[i].e_af));
    end

    // Streaming, registered: each beat appears one cycle after acceptance.
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      s_valid[0] = (k < 16);
      s_aw[0]    = mk(4'(k), 64'(32'h100 * k));
      m_ready[0] = 1'b1;
      stall[0]   = 1'b0;
      @(negedge clk);
      checks++;
      if (occ[0] > 3'd1) begin
        errors++;
        $display("FAIL stream0_occ k=%0d: got %0d expected <=1", k, occ[0]);
      end
      if (k == 0) chk("stream0_first_valid", 64'(m_valid[0]), 64'd0);
      else begin
        chk($sformatf("stream0_valid%0d", k), 64'(m_valid[0]), 64'd1);
        chk($sformatf("stream0_id%0d", k),    64'(m_aw[0].id), 64'(k - 1));
      end
    end
    @(posedge clk); #1 s_valid[0] = 1'b0; m_ready[0] = 1'b0;

    // Streaming, fall-through: each beat appears in its acceptance cycle.
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      s_valid[1] = (k < 16);
      s_aw[1]    = mk(4'(k), 64'(32'h200 * k + 32'h8));
      m_ready[1] = 1'b1;
      @(negedge clk);
      chk($sformatf("stream1_occ%0d", k), 64'(occ[1]), 64'd0);
      if (k < 16) begin
        chk($sformatf("stream1_valid%0d", k), 64'(m_valid[1]), 64'd1);
        chk($sformatf("stream1_id%0d", k),    64'(m_aw[1].id), 64'(k));
      end else chk("stream1_idle_valid", 64'(m_valid[1]), 64'd0);
    end
    @(posedge clk); #1 s_valid[1] = 1'b0; m_ready[1] = 1'b0;

    // Reset mid-operation: three queued beats are dropped.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      s_valid[0] = 1'b1;
      s_aw[0]    = mk(4'(k + 1), 64'(32'h7000 + 32'h10 * k));
    end
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_occ", 64'(occ[0]), 64'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_occ",   64'(occ[0]),     64'd0);
    chk("mid_rst_valid", 64'(m_valid[0]), 64'd0);
    chk("mid_rst_ready", 64'(s_ready[0]), 64'd1);
    @(posedge clk); #1;
    s_valid[0] = 1'b1;
    s_aw[0]    = mk(4'hC, 64'hDEAD_0000_0000_ABC0);
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(m_valid[0]), 64'd1);
    chk("post_rst_addr",  m_aw[0].addr,    64'hDEAD_0000_0000_ABC0);
    @(posedge clk); #1 m_ready[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_occ", 64'(occ[0]), 64'd0);

    // Every accepted beat must have left.
    chk("sb0_leftover", 64'(q0.size()), 64'd0);
    chk("sb1_leftover", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_aw_buffer_cfg.md
Name: axi4_aw_buffer_cfg

Overview:
- Parametrised AXI4 write-address-channel buffer for the RAB slave port.
- Generalises the fixed 32-bit, 4-deep AW buffer with configurable address width, depth and optional empty-bypass (fall-through) mode.
- Adds a downstream stall input, an occupancy count and an almost-full flag.
- Sits between the slave AW port and the RAB lookup so that AW beats are held while translation or miss handling stalls the master side.

Parameters:
- AXI_ID_WIDTH, 4, width of awid.
- AXI_USER_WIDTH, 4, width of awuser.
- AXI_ADDR_WIDTH, 32, width of awaddr; legal range 32..64.
- BUFFER_DEPTH, 4, number of entries; power of two, >= 2.
- FALL_THROUGH, 0:
  - 0: registered output; a beat appears on m_* no earlier than the cycle after acceptance.
  - 1: a beat accepted while the buffer is empty is presented combinationally in the same cycle.
- AFULL_THRESH, BUFFER_DEPTH-1, occupancy at or above which almost_full asserts.

Ports:
- axi4_aclk  in  1  clock.
- axi4_arstn  in  1  reset; synchronous, active-low.
- s_axi4_aw{id,addr,len,size,burst,lock,prot,cache,region,qos,user}  in  ID/ADDR/8/3/2/1/3/4/4/4/USER  slave AW payload.
- s_axi4_awvalid  in  1  slave valid.
- s_axi4_awready  out  1  slave ready.
- m_axi4_aw{id,addr,len,size,burst,lock,prot,cache,region,qos,user}  out  same widths  master AW payload.
- m_axi4_awvalid  out  1  master valid.
- m_axi4_awready  in  1  master ready.
- stall_i  in  1  when high, m_axi4_awvalid is forced low; no beat leaves.
- occupancy_o  out  $clog2(BUFFER_DEPTH+1)  number of stored beats.
- almost_full_o  out  1  occupancy_o >= AFULL_THRESH.

Behaviour:
- Reset: sampled on the rising edge while axi4_arstn=0.
  - Read/write pointers and count clear to 0; stored contents are discarded.
  - Output values during and after reset: s_axi4_awready=1 (after release), m_axi4_awvalid=0, occupancy_o=0, almost_full_o=0; m_* payload is don't-care but must not be X-propagated into valid.
  - Reset mid-operation drops all queued beats with no handshake on either side.
- Storage:
  - Circular array of BUFFER_DEPTH entries, each 61+ADDR-32+ID+USER bits wide.
  - Write and read pointers are $clog2(BUFFER_DEPTH) bits and wrap naturally.
  - Count is held separately so that full and empty are distinguishable.
- Push: s_axi4_awvalid & s_axi4_awready.
- Pop: m_axi4_awvalid & m_axi4_awready.
- s_axi4_awready = (count != BUFFER_DEPTH). It is a function of registered state only; there is no combinational path from m_axi4_awready or stall_i.
- Full, with a pop in the same cycle: no push is accepted that cycle. Ready rises on the following cycle.
- Registered mode (FALL_THROUGH=0):
  - m_axi4_awvalid = (count != 0) & !stall_i.
  - m_* payload = entry[rd_ptr].
  - Push and pop in the same cycle leave count unchanged, with both pointers advancing.
- Fall-through mode (FALL_THROUGH=1):
  - When count==0, m_axi4_awvalid = s_axi4_awvalid & !stall_i and m_* = s_* directly.
  - If the beat is popped in that cycle it is not written and count stays 0.
  - If it is not popped, it is written and count becomes 1.
  - When count!=0, behaviour is identical to registered mode.
- Ordering: strict FIFO; beats leave in acceptance order with all fields bit-exact.
- AXI valid rule:
  - Once m_axi4_awvalid is high, payload is stable until pop, unless stall_i rises.
  - stall_i may withdraw valid. This is permitted only because the downstream is the internal RAB lookup, not an AXI port.
- occupancy_o equals count (registered). almost_full_o is registered-derived from count.
- Pointer wrap: after BUFFER_DEPTH pushes, wr_ptr returns to 0 with no loss of data.

Test Plan:
- Reset, then idle: awready=1, awvalid=0, occupancy=0.
- Depth and wrap (DEPTH=4, FALL_THROUGH=0, m_ready=0):
  - Push addr 0x1000, 0x2000, 0x3000, 0x4000 → occupancy 4, almost_full=1, awready=0.
  - Then m_ready=1 → 4 pops in order 0x1000..0x4000, awready back to 1 on the cycle after the first pop.
- Streaming (m_ready=1):
  - FALL_THROUGH=0: 16 back-to-back beats → each appears 1 cycle after acceptance; occupancy stays <=1; all 16 IDs 0..15 are in order (pointer wrap exercised 4 times).
  - FALL_THROUGH=1, same stimulus → each beat appears in the same cycle and occupancy stays 0.
- Stall: queue 2 beats, hold stall_i=1 for 5 cycles with m_ready=1 → no pops and awvalid=0. Release stall → beats emerge in order on consecutive cycles.
- Full with simultaneous pop (DEPTH=4): s_valid=1 and m_ready=1 in the same cycle while full → exactly one pop, no push, occupancy 3. Push is accepted the next cycle.
- Reset mid-operation: 3 beats queued, assert axi4_arstn=0 for one edge → occupancy 0, awvalid 0. A new beat 0xABC0 is then the first to emerge, with ADDR_WIDTH=64 checked on the upper address bits (0xDEAD_0000_0000_ABC0).
